// File: rtl/ds_slave_bit.sv
// ---------------------------------------------------------------------------
// ds_slave_bit
//   Bit-level 1-Wire responder (device side of the 18B20 bus protocol).
//   Watches the open-drain dq line and does the following:
//   - Classifies each master low pulse as a write/read slot or as a bus reset.
//   - Answers a reset with a presence pulse.
//   - Samples every slot at 30 us.
//   - Holds the line low for 30 us when an armed 0 is to be returned.
//
// Ports
//   clk        system clock (25 MHz nominal)
//   rst        synchronous active-high reset
//   dq_in      raw pad level, asynchronous to clk
//   tx_vld     tx_data is armed for the next slot (sampled at slot start only)
//   tx_data    bit to return in the next read slot
//   tx_ack     1-cycle pulse: armed bit consumed by a completed slot
//   rdata      bit sampled in the last slot
//   rdata_vld  1-cycle pulse qualifying rdata
//   rst_det    1-cycle pulse when a low has lasted long enough to be a reset
//   pres_done  1-cycle pulse at the end of the presence pulse
//   dq_out     constant 0 (open-drain low level)
//   dq_out_en  1 = pull the bus low
//   busy       responder is not idle
// ---------------------------------------------------------------------------
module ds_slave_bit #(
  parameter int CNT_1US       = 25,
  parameter int CNT_SAMPLE    = 30 * CNT_1US,
  parameter int CNT_HOLD      = 30 * CNT_1US,
  parameter int CNT_SLOT      = 60 * CNT_1US,
  parameter int CNT_RST_MIN   = 480 * CNT_1US,
  parameter int CNT_PRES_WAIT = 30 * CNT_1US,
  parameter int CNT_PRES_LEN  = 120 * CNT_1US
) (
  input  logic clk,
  input  logic rst,
  input  logic dq_in,
  input  logic tx_vld,
  input  logic tx_data,
  output logic tx_ack,
  output logic rdata,
  output logic rdata_vld,
  output logic rst_det,
  output logic pres_done,
  output logic dq_out,
  output logic dq_out_en,
  output logic busy
);

  localparam int SYNC_STAGES = 2;

  // Terminal counts, pre-sized to the 15-bit counter.
  localparam logic [14:0] SAMPLE_M1 = 15'(CNT_SAMPLE - 1);
  localparam logic [14:0] HOLD_LEN  = 15'(CNT_HOLD);
  localparam logic [14:0] SLOT_M1   = 15'(CNT_SLOT - 1);
  localparam logic [14:0] RST_M1    = 15'(CNT_RST_MIN - 1);
  localparam logic [14:0] PWAIT_M1  = 15'(CNT_PRES_WAIT - 1);
  localparam logic [14:0] PLEN_M1   = 15'(CNT_PRES_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    RST_LOW,
    PRES_WAIT,
    PRES,
    RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d, cnt_inc;
  logic        arm_vld_q, arm_vld_d;
  logic        arm_bit_q, arm_bit_d;
  logic        rdata_q, rdata_d;
  logic        rdata_vld_q, rdata_vld_d;
  logic        tx_ack_q, tx_ack_d;
  logic        rst_det_q, rst_det_d;
  logic        pres_done_q, pres_done_d;
  logic        dq_out_en_q, dq_out_en_d;
  logic        dq_prev_q;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dq_s;
  logic                   fell;

  // Synchronizer chain for the asynchronous pad level. Stage 0 takes the
  // pad and each later stage takes the one before it.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_d[gi] = dq_in;
    end else begin : g_next
      assign sync_d[gi] = sync_q[gi-1];
    end
  end

  assign dq_s = sync_q[SYNC_STAGES-1];
  assign fell = dq_prev_q & ~dq_s;

  // The counter sticks at the reset threshold. A long low therefore cannot
  // wrap around and be misread as a short slot.
  assign cnt_inc = (cnt_q == RST_M1) ? cnt_q : cnt_q + 15'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    arm_vld_d   = arm_vld_q;
    arm_bit_d   = arm_bit_q;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    tx_ack_d    = 1'b0;
    rst_det_d   = 1'b0;
    pres_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fell) begin
          state_d   = SLOT;
          arm_vld_d = tx_vld;
          arm_bit_d = tx_data;
        end
      end

      SLOT: begin
        if (cnt_q == SAMPLE_M1) begin
          rdata_d     = dq_s;
          rdata_vld_d = 1'b1;
        end
        // A slot only ends once the minimum slot time has elapsed. Early
        // highs and new edges before then are absorbed into this slot.
        if (cnt_q >= SLOT_M1 && dq_s) begin
          state_d   = IDLE;
          cnt_d     = '0;
          tx_ack_d  = arm_vld_q;
          arm_vld_d = 1'b0;
        end else if (cnt_q == RST_M1 && !dq_s) begin
          state_d   = RST_LOW;
          cnt_d     = '0;
          rst_det_d = 1'b1;
          arm_vld_d = 1'b0;
        end
      end

      RST_LOW: begin
        cnt_d = '0;
        if (dq_s) begin
          state_d = PRES_WAIT;
        end
      end

      PRES_WAIT: begin
        if (fell) begin
          // The master re-issued a reset before presence. Treat it as a fresh
          // low, with no bit to return.
          state_d   = SLOT;
          cnt_d     = '0;
          arm_vld_d = 1'b0;
        end else if (cnt_q == PWAIT_M1) begin
          state_d = PRES;
          cnt_d   = '0;
        end
      end

      PRES: begin
        if (cnt_q == PLEN_M1) begin
          state_d     = RECOVER;
          cnt_d       = '0;
          pres_done_d = 1'b1;
        end
      end

      RECOVER: begin
        // Our own presence low is still draining through the synchronizer.
        // Wait for the line to read high, unless the master is holding it
        // low long enough to be a reset.
        if (dq_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RST_M1) begin
          state_d   = RST_LOW;
          cnt_d     = '0;
          rst_det_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        arm_vld_d = 1'b0;
      end
    endcase

    // The drive is decoded from the next state. This way the pad register
    // switches on the same edge as the state/counter it belongs to.
    dq_out_en_d = (state_d == PRES) ||
                  (state_d == SLOT && arm_vld_d && !arm_bit_d && cnt_d < HOLD_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '1;
      dq_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      arm_vld_q   <= 1'b0;
      arm_bit_q   <= 1'b0;
      rdata_q     <= 1'b0;
      rdata_vld_q <= 1'b0;
      tx_ack_q    <= 1'b0;
      rst_det_q   <= 1'b0;
      pres_done_q <= 1'b0;
      dq_out_en_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      dq_prev_q   <= dq_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      arm_vld_q   <= arm_vld_d;
      arm_bit_q   <= arm_bit_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      tx_ack_q    <= tx_ack_d;
      rst_det_q   <= rst_det_d;
      pres_done_q <= pres_done_d;
      dq_out_en_q <= dq_out_en_d;
    end
  end

  assign tx_ack    = tx_ack_q;
  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;
  assign rst_det   = rst_det_q;
  assign pres_done = pres_done_q;
  assign dq_out    = 1'b0;
  assign dq_out_en = dq_out_en_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ds_slave_bit.sv
// ---------------------------------------------------------------------------
// tb_ds_slave_bit
//   Directed bench for ds_slave_bit. A master model drives the open-drain
//   bus, and the line is the wired-AND of master and responder. A negedge
//   monitor counts pulses and records when each one happened. Timing offsets
//   are counted from the posedge after which the master pulled low:
//   - 2 synchronizer cycles plus 1 edge cycle before SLOT starts.
//   - Registered outputs are then seen at the following negedge.
// ---------------------------------------------------------------------------
module tb_ds_slave_bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_vld = 1'b0;
  logic tx_data = 1'b0;
  logic master_low = 1'b0;
  logic dq_in;
  logic tx_ack, rdata, rdata_vld, rst_det, pres_done, dq_out, dq_out_en, busy;

  // Open-drain bus: either side may pull low, otherwise the line idles high.
  assign dq_in = master_low ? 1'b0 : (dq_out_en ? dq_out : 1'b1);

  ds_slave_bit dut (
    .clk       (clk),
    .rst       (rst),
    .dq_in     (dq_in),
    .tx_vld    (tx_vld),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .rdata     (rdata),
    .rdata_vld (rdata_vld),
    .rst_det   (rst_det),
    .pres_done (pres_done),
    .dq_out    (dq_out),
    .dq_out_en (dq_out_en),
    .busy      (busy)
  );

  always #20 clk = ~clk;

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   n_rvld = 0, n_ack = 0, n_rst = 0, n_pres = 0, n_en = 0;
  int   t_rvld = 0, t_ack = 0, t_rst = 0, t_pres = 0, t_en_first = 0, t_en_last = 0;
  logic last_rdata = 1'b0;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rdata_vld) begin
      n_rvld     <= n_rvld + 1;
      last_rdata <= rdata;
      t_rvld     <= cyc + 1;
    end
    if (tx_ack) begin
      n_ack <= n_ack + 1;
      t_ack <= cyc + 1;
    end
    if (rst_det) begin
      n_rst <= n_rst + 1;
      t_rst <= cyc + 1;
    end
    if (pres_done) begin
      n_pres <= n_pres + 1;
      t_pres <= cyc + 1;
    end
    if (dq_out_en) begin
      n_en      <= n_en + 1;
      t_en_last <= cyc + 1;
      if (!en_prev) t_en_first <= cyc + 1;
    end
    en_prev <= dq_out_en;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int s_rvld, s_ack, s_rst, s_pres, s_en;

  task automatic snap();
    s_rvld = n_rvld;
    s_ack  = n_ack;
    s_rst  = n_rst;
    s_pres = n_pres;
    s_en   = n_en;
  endtask

  // Advance n posedges and land just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_low(output int t0);
    tick(1);
    master_low = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic short_slot(input int low_cyc);
    int t0;
    start_low(t0);
    tick(low_cyc);
    master_low = 1'b0;
    tick(1600 - low_cyc);
  endtask

  initial begin
    #(40 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t_rel, n;

    // ---- reset state ----
    tick(5);
    check("rst_en",    {31'd0, dq_out_en}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_rdata", {31'd0, rdata},     32'd0);
    check("rst_pulses", {28'd0, rdata_vld, tx_ack, rst_det, pres_done}, 32'd0);
    check("rst_dqout", {31'd0, dq_out},    32'd0);
    rst = 1'b0;
    tick(5);

    // ---- master write 1: 1 us low ----
    snap();
    start_low(t0);
    tick(25);
    check("w1_busy", {31'd0, busy}, 32'd1);
    master_low = 1'b0;
    tick(1575);
    wait_idle("w1_idle", 100);
    check("w1_nrvld", n_rvld - s_rvld, 1);
    check("w1_trvld", t_rvld - t0, 754);
    check("w1_rdata", {31'd0, last_rdata}, 32'd1);
    check("w1_en",    n_en - s_en, 0);
    check("w1_ack",   n_ack - s_ack, 0);
    $display("[TB] write1 done");

    // ---- master write 0: 60 us low ----
    snap();
    start_low(t0);
    tick(1500);
    check("w0_busy", {31'd0, busy}, 32'd1);
    master_low = 1'b0;
    wait_idle("w0_idle", 100);
    check("w0_tidle", cyc - t0, 1503);
    check("w0_nrvld", n_rvld - s_rvld, 1);
    check("w0_rdata", {31'd0, last_rdata}, 32'd0);
    $display("[TB] write0 done");

    // ---- read slot returning 0 (tx changes mid-slot are ignored) ----
    snap();
    tx_vld  = 1'b1;
    tx_data = 1'b0;
    start_low(t0);
    tick(10);
    tx_vld  = 1'b0;
    tx_data = 1'b1;
    tick(15);
    master_low = 1'b0;
    tick(1575);
    wait_idle("r0_idle", 100);
    check("r0_nen",   n_en - s_en, 750);
    check("r0_en_on", t_en_first - t0, 4);
    check("r0_en_off", t_en_last - t0, 753);
    check("r0_rdata", {31'd0, last_rdata}, 32'd0);
    check("r0_nack",  n_ack - s_ack, 1);
    check("r0_tack",  t_ack - t0, 1504);
    $display("[TB] read0 done");

    // ---- read slot returning 1 ----
    snap();
    tx_vld  = 1'b1;
    tx_data = 1'b1;
    start_low(t0);
    tick(25);
    master_low = 1'b0;
    tx_vld = 1'b0;
    tick(1575);
    wait_idle("r1_idle", 100);
    check("r1_nen",   n_en - s_en, 0);
    check("r1_rdata", {31'd0, last_rdata}, 32'd1);
    check("r1_nack",  n_ack - s_ack, 1);
    $display("[TB] read1 done");

    // ---- bus reset and presence ----
    snap();
    start_low(t0);
    tick(12500);
    master_low = 1'b0;
    t_rel = cyc;
    wait_idle("rs_idle", 5000);
    check("rs_nrst",   n_rst - s_rst, 1);
    check("rs_trst",   t_rst - t0, 12004);
    check("rs_nen",    n_en - s_en, 3000);
    check("rs_en_on",  t_en_first - t_rel, 754);
    check("rs_en_off", t_en_last - t_rel, 3753);
    check("rs_npres",  n_pres - s_pres, 1);
    check("rs_tpres",  t_pres - t_rel, 3754);
    check("rs_nack",   n_ack - s_ack, 0);
    $display("[TB] reset/presence done");

    // ---- reset during an armed read slot ----
    snap();
    tx_vld  = 1'b1;
    tx_data = 1'b0;
    start_low(t0);
    tick(10);
    tx_vld = 1'b0;
    tick(12490);
    master_low = 1'b0;
    wait_idle("ra_idle", 6000);
    check("ra_nack",  n_ack - s_ack, 0);
    check("ra_nrst",  n_rst - s_rst, 1);
    check("ra_npres", n_pres - s_pres, 1);
    check("ra_nen",   n_en - s_en, 3750);
    snap();
    short_slot(25);
    wait_idle("ra2_idle", 100);
    check("ra2_rdata", {31'd0, last_rdata}, 32'd1);
    check("ra2_nen",   n_en - s_en, 0);
    check("ra2_nack",  n_ack - s_ack, 0);
    $display("[TB] reset-in-read done");

    // ---- rst asserted during presence ----
    start_low(t0);
    tick(12500);
    master_low = 1'b0;
    n = 0;
    while (!dq_out_en && n < 1000) begin
      tick(1);
      n++;
    end
    check("pr_en_on", {31'd0, dq_out_en}, 32'd1);
    tick(100);
    snap();
    rst = 1'b1;
    tick(1);
    check("pr_en",   {31'd0, dq_out_en}, 32'd0);
    check("pr_busy", {31'd0, busy}, 32'd0);
    check("pr_pulses", {28'd0, rdata_vld, tx_ack, rst_det, pres_done}, 32'd0);
    rst = 1'b0;
    tick(3200);
    check("pr_npres", n_pres - s_pres, 0);
    check("pr_idle",  {31'd0, busy}, 32'd0);
    snap();
    short_slot(25);
    wait_idle("pr2_idle", 100);
    check("pr2_nrvld", n_rvld - s_rvld, 1);
    check("pr2_rdata", {31'd0, last_rdata}, 32'd1);
    $display("[TB] rst-in-presence done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
